// File: rtl/bit_stream_serializer.sv
// -----------------------------------------------------------------------------
// bit_stream_serializer
//
// Parallel-to-serial pattern source for the sequence-detector stage. A WIDTH-bit
// word is captured on an accepted load and shifted out MSB-first on `x`, each
// bit held for DIV clock cycles. With repeat_en=1 the same word restarts right
// after its last bit, so the detector sees back-to-back and overlapping
// patterns.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   DIV        clock cycles each bit is held on `x` (1..255)
//
// Ports
//   clk        system clock, rising-edge active
//   reset      asynchronous active-low reset (0 = in reset)
//   load       start request, honoured only while ready=1
//   data       word to serialize, captured on an accepted load
//   repeat_en  1 = restart the same word after its last bit
//   x          serial bit, MSB first (0 when idle)
//   x_valid    1 while `x` carries a word bit
//   ready      1 in IDLE (a load will be accepted)
//   busy       1 in SHIFT
//   done       one-cycle pulse when a word completes and the block goes idle
//   bit_idx    index of the bit currently on `x`; 0 when idle
//
// Every output comes straight from a flop (or a decode of the one-bit state
// flop), so there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module bit_stream_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         data,
    input  logic                     repeat_en,
    output logic                     x,
    output logic                     x_valid,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int DIV_W = $clog2(DIV + 1);

    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;   // MSB is the bit on `x`
    logic [WIDTH-1:0]   word_q,  word_d;    // untouched copy for repeat mode
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [DIV_W-1:0]   div_q,   div_d;
    logic               done_q,  done_d;

    // Last cycle of the current bit's DIV-cycle hold. With DIV=1 the counter
    // never leaves 0, so every cycle is a bit boundary.
    logic               bit_end;
    assign bit_end = (div_q == DIV_LAST);

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        shift_d = shift_q;
        word_d  = word_q;
        idx_d   = idx_q;
        div_d   = div_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = data;
                    word_d  = data;
                    idx_d   = IDX_MSB;
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (!bit_end) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (idx_q != '0) begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        idx_d   = idx_q - 1'b1;
                    end else if (repeat_en) begin
                        // Seamless restart: the word's MSB follows its LSB
                        // with no idle cycle and no done pulse.
                        shift_d = word_q;
                        idx_d   = IDX_MSB;
                    end else begin
                        // Clearing the shift register forces x=0 while idle.
                        shift_d = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: the word copy and shift register are plain flops, not a memory
    // array, so resetting them is cheap and guarantees nothing from an
    // interrupted word can leak out after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: direct flop outputs or a decode of the state flop only
    // -------------------------------------------------------------------------
    assign x       = shift_q[WIDTH-1];
    assign x_valid = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT);
    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign bit_idx = idx_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_stream_serializer
//
// Directed bench for bit_stream_serializer. Three instances share one clock and
// reset:
//   dut_a  WIDTH=8, DIV=1   basic word, ignored load, back-to-back load,
//                           1101 pattern stream, asynchronous reset
//   dut_b  WIDTH=8, DIV=3   bit hold of three cycles
//   dut_c  WIDTH=4, DIV=1   repeat mode and its release
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_bit_stream_serializer;

    logic clk;
    logic reset;

    // dut_a
    logic       load_a, rep_a;
    logic [7:0] data_a;
    logic       x_a, v_a, rdy_a, busy_a, done_a;
    logic [2:0] idx_a;

    // dut_b
    logic       load_b, rep_b;
    logic [7:0] data_b;
    logic       x_b, v_b, rdy_b, busy_b, done_b;
    logic [2:0] idx_b;

    // dut_c
    logic       load_c, rep_c;
    logic [3:0] data_c;
    logic       x_c, v_c, rdy_c, busy_c, done_c;
    logic [1:0] idx_c;

    int n_checks = 0;
    int n_pass   = 0;

    bit_stream_serializer #(.WIDTH(8), .DIV(1)) dut_a (
        .clk(clk), .reset(reset), .load(load_a), .data(data_a), .repeat_en(rep_a),
        .x(x_a), .x_valid(v_a), .ready(rdy_a), .busy(busy_a), .done(done_a),
        .bit_idx(idx_a)
    );

    bit_stream_serializer #(.WIDTH(8), .DIV(3)) dut_b (
        .clk(clk), .reset(reset), .load(load_b), .data(data_b), .repeat_en(rep_b),
        .x(x_b), .x_valid(v_b), .ready(rdy_b), .busy(busy_b), .done(done_b),
        .bit_idx(idx_b)
    );

    bit_stream_serializer #(.WIDTH(4), .DIV(1)) dut_c (
        .clk(clk), .reset(reset), .load(load_c), .data(data_c), .repeat_en(rep_c),
        .x(x_c), .x_valid(v_c), .ready(rdy_c), .busy(busy_c), .done(done_c),
        .bit_idx(idx_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "time limit expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [7:0] w8;
        logic [3:0] w4;
        logic [3:0] hist;
        int         det;
        logic [2:0] det_idx0, det_idx1;
        int         valid_cycles;

        reset  = 1'b0;
        load_a = 1'b0; rep_a = 1'b0; data_a = '0;
        load_b = 1'b0; rep_b = 1'b0; data_b = '0;
        load_c = 1'b0; rep_c = 1'b0; data_c = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_x",     {31'd0, x_a},    32'd0);
        check("rst_valid", {31'd0, v_a},    32'd0);
        check("rst_ready", {31'd0, rdy_a},  32'd1);
        check("rst_busy",  {31'd0, busy_a}, 32'd0);
        check("rst_done",  {31'd0, done_a}, 32'd0);
        check("rst_idx",   {29'd0, idx_a},  32'd0);
        check("rst_ready_b", {31'd0, rdy_b}, 32'd1);
        check("rst_ready_c", {31'd0, rdy_c}, 32'd1);
        reset = 1'b1;
        tick();

        // ---------------- T1: WIDTH=8 DIV=1, 1101_0110 ----------------
        w8 = 8'b1101_0110;
        load_a = 1'b1; data_a = w8;
        tick();
        load_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t1_x",     {31'd0, x_a},    {31'd0, w8[7-i]});
            check("t1_valid", {31'd0, v_a},    32'd1);
            check("t1_idx",   {29'd0, idx_a},  32'(7 - i));
            check("t1_busy",  {31'd0, busy_a}, 32'd1);
            check("t1_ready", {31'd0, rdy_a},  32'd0);
            check("t1_done",  {31'd0, done_a}, 32'd0);
            tick();
        end
        check("t1_done_pulse", {31'd0, done_a}, 32'd1);
        check("t1_end_valid",  {31'd0, v_a},    32'd0);
        check("t1_end_ready",  {31'd0, rdy_a},  32'd1);
        check("t1_end_x",      {31'd0, x_a},    32'd0);
        tick();
        check("t1_done_clear", {31'd0, done_a}, 32'd0);

        // ---------------- T2: WIDTH=8 DIV=3 ----------------
        load_b = 1'b1; data_b = w8;
        tick();
        load_b = 1'b0;
        valid_cycles = 0;
        for (int c = 0; c < 24; c++) begin
            check("t2_x",   {31'd0, x_b},   {31'd0, w8[7 - c/3]});
            check("t2_idx", {29'd0, idx_b}, 32'(7 - c/3));
            if (v_b) valid_cycles++;
            tick();
        end
        check("t2_valid_cycles", 32'(valid_cycles), 32'd24);
        check("t2_done_pulse",   {31'd0, done_b},   32'd1);
        check("t2_end_valid",    {31'd0, v_b},      32'd0);
        tick();
        check("t2_done_clear",   {31'd0, done_b},   32'd0);

        // ---------------- T3: WIDTH=4 repeat 1101 ----------------
        w4 = 4'b1101;
        rep_c = 1'b1; load_c = 1'b1; data_c = w4;
        tick();
        load_c = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check("t3_x",     {31'd0, x_c},    {31'd0, w4[3 - (c % 4)]});
            check("t3_idx",   {30'd0, idx_c},  32'(3 - (c % 4)));
            check("t3_valid", {31'd0, v_c},    32'd1);
            check("t3_done",  {31'd0, done_c}, 32'd0);
            tick();
        end
        // Drop repeat_en while the fourth word's MSB is on x.
        rep_c = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("t3_last_x",    {31'd0, x_c},    {31'd0, w4[3 - c]});
            check("t3_last_done", {31'd0, done_c}, 32'd0);
            tick();
        end
        check("t3_done_pulse", {31'd0, done_c}, 32'd1);
        check("t3_end_valid",  {31'd0, v_c},    32'd0);
        tick();
        check("t3_done_clear", {31'd0, done_c}, 32'd0);
        check("t3_end_ready",  {31'd0, rdy_c},  32'd1);

        // ---------------- T4: ignored load, load on done cycle ----------------
        w8 = 8'hA5;
        load_a = 1'b1; data_a = w8;
        tick();
        load_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // Cycle 3 (i==2): a load of 8'hFF that must be ignored.
            if (i == 2) begin
                load_a = 1'b1; data_a = 8'hFF;
            end else begin
                load_a = 1'b0; data_a = 8'h00;
            end
            check("t4_x", {31'd0, x_a}, {31'd0, w8[7-i]});
            tick();
        end
        check("t4_done_pulse", {31'd0, done_a}, 32'd1);
        check("t4_gap_valid",  {31'd0, v_a},    32'd0);
        w8 = 8'h0F;
        load_a = 1'b1; data_a = w8;
        tick();
        load_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t4_b2b_x",     {31'd0, x_a}, {31'd0, w8[7-i]});
            check("t4_b2b_valid", {31'd0, v_a}, 32'd1);
            tick();
        end
        check("t4_b2b_done", {31'd0, done_a}, 32'd1);
        tick();

        // ---------------- T6: 1101 pattern stream for the detector ----------------
        w8   = 8'b1101_1010;
        hist = '0;
        det  = 0;
        det_idx0 = '0;
        det_idx1 = '0;
        load_a = 1'b1; data_a = w8;
        tick();
        load_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (v_a) begin
                hist = {hist[2:0], x_a};
                if (hist == 4'b1101) begin
                    det++;
                    if (det == 1) det_idx0 = idx_a;
                    else          det_idx1 = idx_a;
                end
            end
            tick();
        end
        check("t6_det_count", 32'(det),           32'd2);
        check("t6_det_idx0",  {29'd0, det_idx0},  32'd4);
        check("t6_det_idx1",  {29'd0, det_idx1},  32'd1);
        tick();

        // ---------------- T5: asynchronous reset mid-word ----------------
        w8 = 8'b1101_0110;
        load_a = 1'b1; data_a = w8;
        tick();
        load_a = 1'b0;
        tick(); tick(); tick();
        // Cycle 4: bit 4 (=1) on x.
        check("t5_pre_x",     {31'd0, x_a}, 32'd1);
        check("t5_pre_valid", {31'd0, v_a}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_x",     {31'd0, x_a},    32'd0);
        check("t5_async_valid", {31'd0, v_a},    32'd0);
        check("t5_async_busy",  {31'd0, busy_a}, 32'd0);
        check("t5_async_done",  {31'd0, done_a}, 32'd0);
        check("t5_async_ready", {31'd0, rdy_a},  32'd1);
        check("t5_async_idx",   {29'd0, idx_a},  32'd0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_post_valid", {31'd0, v_a},   32'd0);
            check("t5_post_ready", {31'd0, rdy_a}, 32'd1);
            check("t5_post_x",     {31'd0, x_a},   32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
Parallel-to-serial pattern source that feeds the serial input `x` of the sequence-detector stage. It loads a WIDTH-bit word and shifts it out MSB-first, one bit per DIV clock cycles, with a valid qualifier. An optional repeat mode streams the same word continuously so the detector sees overlapping and back-to-back patterns. It sits directly upstream of the detector and shares its clock.

Parameters:
WIDTH, 8, number of bits per word; legal range 2..32.
DIV, 1, clock cycles each bit is held on `x`; legal range 1..255.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
load  input  1  request to start shifting `data`; sampled only when ready=1.
data  input  WIDTH  word to serialize; captured on an accepted load.
repeat_en  input  1  1 = restart the same word immediately after its last bit.
x  output  1  serial bit to the detector, MSB first.
x_valid  output  1  1 while `x` carries a word bit.
ready  output  1  1 in IDLE (load will be accepted).
busy  output  1  1 in SHIFT.
done  output  1  one-cycle pulse when a word completes and the block returns to IDLE.
bit_idx  output  $clog2(WIDTH)  index of the bit currently on `x` (WIDTH-1 down to 0); 0 in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; shift register, word copy, bit counter and DIV counter cleared; x=0, x_valid=0, busy=0, done=0, bit_idx=0, ready=1. Applies immediately, including mid-word. No partial word resumes after reset deasserts.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states:
  - IDLE: ready=1. If load=1 at a rising edge, capture data into the shift register and the word copy, bit_idx<=WIDTH-1, DIV counter<=0, go to SHIFT. In the cycle after acceptance, x=data[WIDTH-1] and x_valid=1 (latency 1).
  - SHIFT: ready=0, busy=1, x_valid=1. The DIV counter increments each cycle. When it reaches DIV-1, the counter resets to 0, and:
    - if bit_idx>0: shift left, so x takes the next lower bit, and bit_idx decrements;
    - if bit_idx==0 and repeat_en=1: reload from the word copy, bit_idx<=WIDTH-1, stay in SHIFT. The new word's MSB follows with no gap and done stays 0;
    - if bit_idx==0 and repeat_en=0: go to IDLE with x<=0, x_valid<=0 and done<=1 for exactly one cycle.
- Each bit is held for exactly DIV cycles. A non-repeat word occupies exactly WIDTH*DIV cycles of x_valid=1.
- `load` and `data` are ignored during SHIFT. The word copy never changes mid-stream.
- A load asserted in the same cycle that done=1 is accepted, because the block is in IDLE. The first bit appears in the next cycle, giving a one-cycle gap between words.
- repeat_en is sampled only at the last-bit boundary. Deasserting it mid-word finishes the current word and then returns to IDLE.
- DIV counter width is $clog2(DIV+1). With DIV=1 the counter is always 0 and a bit advances every cycle.

Test Plan:
- WIDTH=8, DIV=1; load data=8'b1101_0110 at cycle 0 -> x=1,1,0,1,0,1,1,0 on cycles 1..8 with x_valid=1 and bit_idx=7..0; done=1 on cycle 9 only, then x_valid=0 and ready=1.
- WIDTH=8, DIV=3; same load -> each bit held 3 cycles (cycles 1-3 x=1, 4-6 x=1, 7-9 x=0, ...); x_valid high for 24 cycles; done on cycle 25.
- WIDTH=4, DIV=1, repeat_en=1, data=4'b1101 -> continuous x=1101 1101 1101... with no gaps and done never 1. Drop repeat_en mid-word -> the current word completes, then done pulses once.
- Load 8'hA5, then pulse load with 8'hFF on cycle 3 -> 8'hFF ignored and the stream equals 10100101. A load on the done cycle with 8'h0F -> x_valid gap of exactly 1 cycle, then 00001111.
- Assert reset=0 asynchronously (between edges) on cycle 4 of a DIV=1 word -> x, x_valid, busy and done go 0 and ready goes 1 without waiting for a clock edge. After release, no bits are emitted until a new load.
- Chain with the detector, WIDTH=8, data=8'b1101_1010 -> the detector sees 1101 ending at bit_idx=4 and reports a detection per its own latency; the overlapping 1101 (bits 4..1) is also reported.
